decode_unit: RTL and testbench
==============================

# decode_unit

Instruction decoder of the CPU core (RTL module name: decode_unit). It sits between fetch and the register file/ALU/PC unit. It takes one 16-bit instruction word per strobe and produces registered control signals for those units one cycle later.

## Interface
- No parameters.
- cpu_clk  in  1  core clock; all state updates on the rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- ins  in  16  instruction word.
- ins_en  in  1  instruction valid strobe.
- ext  in  16  extension word following ins.
  - Held by fetch and selected by the PC unit when pc_src=1.
  - Reserved in this block: no output depends on ext.
- imm_en  out  1  the ALU B operand is arg_imm.
- arg_imm  out  5  immediate, shift amount or branch offset.
- read_a  out  1  read register arg_a.
- arg_a  out  4  A source register, also the destination register.
- read_b  out  1  read register src_b.
- src_b  out  4  B source register.
- set_pc  out  1  load PC absolutely.
- add_pc  out  1  add arg_imm to PC if the condition holds.
- inc_pc  out  1  PC+1.
- pc_src  out  2  PC source: 0 none, 1 ext, 2 register A, 3 immediate.
- cmp_b  out  3  branch condition: 0 always, 1 eq, 2 ne, 3 lt, 4 ge, 5 ltu, 6 geu, 7 never.
- out_regs  out  3  writeback mask: bit0 dest reg, bit1 flags, bit2 link register.
- alu_en  out  1  ALU operation valid.
- sh_off_imm  out  1  shift amount comes from arg_imm instead of register B.
- truth_table  out  4  LUT for the logic operation.
- alu_op  out  5  ALU operation code.

## Operation
Opcode is ins[15:12]. The default value of every output is 0 unless listed for an opcode.

- 0x0 NOP
  - inc_pc=1.
- 0x1 ALU reg-reg: a=ins[11:8], b=ins[7:4], func=ins[3:0]
  - read_a=1, arg_a=a, read_b=1, src_b=b.
  - alu_en=1, alu_op={0,func}, out_regs=011, inc_pc=1.
- 0x2 ALU imm: a=ins[11:8], f3=ins[7:5], imm=ins[4:0]
  - read_a=1, arg_a=a, imm_en=1, arg_imm=imm.
  - alu_en=1, alu_op={00,f3}, out_regs=011, inc_pc=1.
- 0x3 logic: a, b as in 0x1
  - read_a, read_b, alu_en=1, alu_op=5'h10, truth_table=ins[3:0], out_regs=011, inc_pc=1.
- 0x4 shift imm: a=ins[11:8], kind=ins[7:6], shamt=ins[4:0]
  - read_a=1, imm_en=1, sh_off_imm=1, arg_imm=shamt.
  - alu_en=1, alu_op=5'h14+kind, out_regs=011, inc_pc=1.
- 0x5 shift reg: a, b as in 0x1, kind=ins[1:0]
  - read_a, read_b, sh_off_imm=0, alu_en=1, alu_op=5'h14+kind, out_regs=011, inc_pc=1.
- 0x6 compare: a, b as in 0x1
  - read_a, read_b, alu_en=1, alu_op=5'h18, out_regs=010, inc_pc=1.
- 0x7 branch: cmp_b=ins[11:9]
  - add_pc=1, pc_src=3, imm_en=1, arg_imm=ins[4:0] (signed offset), inc_pc=0.
  - The PC unit applies PC+1 when the condition is false.
- 0x8 jump: a=ins[11:8], mode=ins[1], link=ins[2]
  - set_pc=1, cmp_b=0, inc_pc=0.
  - mode=1: read_a=1, arg_a=a, pc_src=2.
  - mode=0: pc_src=1.
  - out_regs={link,00}.
- 0x9–0xF: decoded as NOP (inc_pc=1 only).
- Decode is purely combinational from ins into a single output register stage.

## Timing
- All outputs are registered. Latency is 1 cycle: an ins sampled with ins_en=1 at edge N appears on the outputs after edge N.
- ins_en=0 at an edge: every output registers to 0 (bubble, including inc_pc=0).
- No back-pressure; a new instruction may be accepted every cycle.
- cpu_rst=1 at an edge: every output becomes 0. Reset overrides ins_en. The first valid decode is the edge after cpu_rst deasserts.
- Reset mid-stream discards the instruction sampled on that edge.

## Test plan
- Reset with ins_en=1 and ins=16'h1234 -> all outputs 0 next cycle.
- ins=16'h1A53, ins_en=1 -> next cycle:
  - read_a=1, arg_a=4'hA, read_b=1, src_b=5;
  - alu_en=1, alu_op=5'h03, out_regs=3'b011, inc_pc=1;
  - all else 0.
- ins=16'h3126 -> alu_op=5'h10, truth_table=4'h6, arg_a=1, src_b=2, out_regs=011.
- ins=16'h4347 -> arg_a=3, alu_op=5'h15, sh_off_imm=1, imm_en=1, arg_imm=7, read_b=0.
- ins=16'h761F -> cmp_b=3, add_pc=1, pc_src=3, imm_en=1, arg_imm=5'h1F, inc_pc=0.
- Three consecutive inputs:
  - ins=16'h8506 -> set_pc=1, pc_src=2, read_a=1, arg_a=5, out_regs=100, inc_pc=0.
  - Next cycle ins_en=0 -> all outputs 0.
  - Next cycle ins=16'hF000 -> inc_pc=1 only.
  - Outputs must be identical for ext=16'h0000 and ext=16'hFFFF.

Source files
------------

// File: rtl/decode_unit.sv
// Instruction decoder: turns one 16-bit instruction word per strobe into
// registered control signals for the register file, ALU and PC unit.
module decode_unit (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [15:0] ins,
   input  logic        ins_en,
   input  logic [15:0] ext,
   output logic        imm_en,
   output logic [4:0]  arg_imm,
   output logic        read_a,
   output logic [3:0]  arg_a,
   output logic        read_b,
   output logic [3:0]  src_b,
   output logic        set_pc,
   output logic        add_pc,
   output logic        inc_pc,
   output logic [1:0]  pc_src,
   output logic [2:0]  cmp_b,
   output logic [2:0]  out_regs,
   output logic        alu_en,
   output logic        sh_off_imm,
   output logic [3:0]  truth_table,
   output logic [4:0]  alu_op
);

   typedef enum logic [3:0] {
      OP_NOP       = 4'h0,
      OP_ALU_RR    = 4'h1,
      OP_ALU_IMM   = 4'h2,
      OP_LOGIC     = 4'h3,
      OP_SHIFT_IMM = 4'h4,
      OP_SHIFT_REG = 4'h5,
      OP_CMP       = 4'h6,
      OP_BRANCH    = 4'h7,
      OP_JUMP      = 4'h8
   } opcode_e;

   typedef struct packed {
      logic       imm_en;
      logic [4:0] arg_imm;
      logic       read_a;
      logic [3:0] arg_a;
      logic       read_b;
      logic [3:0] src_b;
      logic       set_pc;
      logic       add_pc;
      logic       inc_pc;
      logic [1:0] pc_src;
      logic [2:0] cmp_b;
      logic [2:0] out_regs;
      logic       alu_en;
      logic       sh_off_imm;
      logic [3:0] truth_table;
      logic [4:0] alu_op;
   } ctrl_t;

   logic [3:0] w_opcode;
   logic [3:0] w_reg_a;
   logic [3:0] w_reg_b;
   logic       w_unused;
   ctrl_t      w_ctrl;
   ctrl_t      r_ctrl;

   assign w_opcode = ins[15:12];
   assign w_reg_a  = ins[11:8];
   assign w_reg_b  = ins[7:4];
   // The extension word is consumed by the PC unit, not here.
   assign w_unused = ^ext;

   always_comb begin
      // NOTE: every field gets a default before the case so no latch is inferred.
      w_ctrl        = '0;
      w_ctrl.inc_pc = 1'b1;
      case (w_opcode)
         OP_ALU_RR: begin
            w_ctrl.read_a   = 1'b1;
            w_ctrl.arg_a    = w_reg_a;
            w_ctrl.read_b   = 1'b1;
            w_ctrl.src_b    = w_reg_b;
            w_ctrl.alu_en   = 1'b1;
            w_ctrl.alu_op   = {1'b0, ins[3:0]};
            w_ctrl.out_regs = 3'b011;
         end
         OP_ALU_IMM: begin
            w_ctrl.read_a   = 1'b1;
            w_ctrl.arg_a    = w_reg_a;
            w_ctrl.imm_en   = 1'b1;
            w_ctrl.arg_imm  = ins[4:0];
            w_ctrl.alu_en   = 1'b1;
            w_ctrl.alu_op   = {2'b00, ins[7:5]};
            w_ctrl.out_regs = 3'b011;
         end
         OP_LOGIC: begin
            w_ctrl.read_a      = 1'b1;
            w_ctrl.arg_a       = w_reg_a;
            w_ctrl.read_b      = 1'b1;
            w_ctrl.src_b       = w_reg_b;
            w_ctrl.alu_en      = 1'b1;
            w_ctrl.alu_op      = 5'h10;
            w_ctrl.truth_table = ins[3:0];
            w_ctrl.out_regs    = 3'b011;
         end
         OP_SHIFT_IMM: begin
            w_ctrl.read_a     = 1'b1;
            w_ctrl.arg_a      = w_reg_a;
            w_ctrl.imm_en     = 1'b1;
            w_ctrl.sh_off_imm = 1'b1;
            w_ctrl.arg_imm    = ins[4:0];
            w_ctrl.alu_en     = 1'b1;
            w_ctrl.alu_op     = 5'h14 + {3'b000, ins[7:6]};
            w_ctrl.out_regs   = 3'b011;
         end
         OP_SHIFT_REG: begin
            w_ctrl.read_a   = 1'b1;
            w_ctrl.arg_a    = w_reg_a;
            w_ctrl.read_b   = 1'b1;
            w_ctrl.src_b    = w_reg_b;
            w_ctrl.alu_en   = 1'b1;
            w_ctrl.alu_op   = 5'h14 + {3'b000, ins[1:0]};
            w_ctrl.out_regs = 3'b011;
         end
         OP_CMP: begin
            w_ctrl.read_a   = 1'b1;
            w_ctrl.arg_a    = w_reg_a;
            w_ctrl.read_b   = 1'b1;
            w_ctrl.src_b    = w_reg_b;
            w_ctrl.alu_en   = 1'b1;
            w_ctrl.alu_op   = 5'h18;
            w_ctrl.out_regs = 3'b010;
         end
         OP_BRANCH: begin
            // PC+1 on a false condition is applied by the PC unit itself.
            w_ctrl.inc_pc  = 1'b0;
            w_ctrl.add_pc  = 1'b1;
            w_ctrl.pc_src  = 2'd3;
            w_ctrl.cmp_b   = ins[11:9];
            w_ctrl.imm_en  = 1'b1;
            w_ctrl.arg_imm = ins[4:0];
         end
         OP_JUMP: begin
            w_ctrl.inc_pc   = 1'b0;
            w_ctrl.set_pc   = 1'b1;
            w_ctrl.out_regs = {ins[2], 2'b00};
            if (ins[1]) begin
               w_ctrl.read_a = 1'b1;
               w_ctrl.arg_a  = w_reg_a;
               w_ctrl.pc_src = 2'd2;
            end else begin
               w_ctrl.pc_src = 2'd1;
            end
         end
         default: ;
      endcase
   end

   // A bubble (ins_en=0) clears everything, inc_pc included.
   always_ff @(posedge cpu_clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (cpu_rst)     r_ctrl <= '0;
      else if (ins_en) r_ctrl <= w_ctrl;
      else             r_ctrl <= '0;
   end

   assign imm_en      = r_ctrl.imm_en;
   assign arg_imm     = r_ctrl.arg_imm;
   assign read_a      = r_ctrl.read_a;
   assign arg_a       = r_ctrl.arg_a;
   assign read_b      = r_ctrl.read_b;
   assign src_b       = r_ctrl.src_b;
   assign set_pc      = r_ctrl.set_pc;
   assign add_pc      = r_ctrl.add_pc;
   assign inc_pc      = r_ctrl.inc_pc;
   assign pc_src      = r_ctrl.pc_src;
   assign cmp_b       = r_ctrl.cmp_b;
   assign out_regs    = r_ctrl.out_regs;
   assign alu_en      = r_ctrl.alu_en;
   assign sh_off_imm  = r_ctrl.sh_off_imm;
   assign truth_table = r_ctrl.truth_table;
   assign alu_op      = r_ctrl.alu_op;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed table, hand sequences for
// reset/bubble corners, and random instructions against a reference model.
module tb_decode_unit;

   typedef struct packed {
      logic       imm_en;
      logic [4:0] arg_imm;
      logic       read_a;
      logic [3:0] arg_a;
      logic       read_b;
      logic [3:0] src_b;
      logic       set_pc;
      logic       add_pc;
      logic       inc_pc;
      logic [1:0] pc_src;
      logic [2:0] cmp_b;
      logic [2:0] out_regs;
      logic       alu_en;
      logic       sh_off_imm;
      logic [3:0] truth_table;
      logic [4:0] alu_op;
   } out_t;

   typedef struct {
      string       name;
      logic [15:0] ins;
      logic [15:0] ext;
      logic        en;
      out_t        exp;
   } vec_t;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [15:0] ins;
   logic        ins_en;
   logic [15:0] ext;
   logic        imm_en, read_a, read_b, set_pc, add_pc, inc_pc, alu_en, sh_off_imm;
   logic [4:0]  arg_imm, alu_op;
   logic [3:0]  arg_a, src_b, truth_table;
   logic [1:0]  pc_src;
   logic [2:0]  cmp_b, out_regs;

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs[$];

   decode_unit dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .ins(ins), .ins_en(ins_en), .ext(ext),
      .imm_en(imm_en), .arg_imm(arg_imm), .read_a(read_a), .arg_a(arg_a),
      .read_b(read_b), .src_b(src_b), .set_pc(set_pc), .add_pc(add_pc),
      .inc_pc(inc_pc), .pc_src(pc_src), .cmp_b(cmp_b), .out_regs(out_regs),
      .alu_en(alu_en), .sh_off_imm(sh_off_imm), .truth_table(truth_table),
      .alu_op(alu_op)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic out_t actual();
      out_t a;
      a = '{imm_en, arg_imm, read_a, arg_a, read_b, src_b, set_pc, add_pc, inc_pc,
            pc_src, cmp_b, out_regs, alu_en, sh_off_imm, truth_table, alu_op};
      return a;
   endfunction

   // Reference model: each output derived from which opcode classes use it.
   function automatic out_t ref_decode(input logic [15:0] w);
      out_t r;
      int   op;
      op = int'(w[15:12]);
      if (op > 8) op = 0;
      r = '0;
      r.inc_pc     = !(op == 7 || op == 8);
      r.read_a     = (op >= 1 && op <= 6) || (op == 8 && w[1]);
      r.arg_a      = r.read_a ? w[11:8] : 4'd0;
      r.read_b     = (op == 1 || op == 3 || op == 5 || op == 6);
      r.src_b      = r.read_b ? w[7:4] : 4'd0;
      r.alu_en     = (op >= 1 && op <= 6);
      r.imm_en     = (op == 2 || op == 4 || op == 7);
      r.arg_imm    = r.imm_en ? w[4:0] : 5'd0;
      r.sh_off_imm = (op == 4);
      r.truth_table = (op == 3) ? w[3:0] : 4'd0;
      if (op >= 1 && op <= 5)  r.out_regs = 3'b011;
      else if (op == 6)        r.out_regs = 3'b010;
      else if (op == 8)        r.out_regs = w[2] ? 3'b100 : 3'b000;
      case (op)
         1: r.alu_op = 5'(int'(w[3:0]));
         2: r.alu_op = 5'(int'(w[7:5]));
         3: r.alu_op = 5'd16;
         4: r.alu_op = 5'(20 + int'(w[7:6]));
         5: r.alu_op = 5'(20 + int'(w[1:0]));
         6: r.alu_op = 5'd24;
         default: r.alu_op = 5'd0;
      endcase
      r.set_pc = (op == 8);
      r.add_pc = (op == 7);
      r.cmp_b  = (op == 7) ? w[11:9] : 3'd0;
      r.pc_src = (op == 7) ? 2'd3 : (op == 8) ? (w[1] ? 2'd2 : 2'd1) : 2'd0;
      return r;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [15:0] i, input logic [15:0] e,
                       input logic en, input logic rst);
      @(negedge cpu_clk);
      ins = i; ext = e; ins_en = en; cpu_rst = rst;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic add_vec(input string name, input logic [15:0] i, input out_t e);
      vec_t v;
      v.name = name; v.ins = i; v.ext = 16'h0000; v.en = 1'b1; v.exp = e;
      vecs.push_back(v);
      v.name = {name, "_extF"}; v.ext = 16'hFFFF;
      vecs.push_back(v);
   endtask

   out_t e;
   out_t e_jump;
   out_t e_nop;

   initial begin
      cpu_rst = 1'b1; ins = 16'h0; ins_en = 1'b0; ext = 16'h0;

      // Directed table, expectations written by hand.
      e = '0; e.read_a = 1; e.arg_a = 4'hA; e.read_b = 1; e.src_b = 4'h5;
      e.alu_en = 1; e.alu_op = 5'h03; e.out_regs = 3'b011; e.inc_pc = 1;
      add_vec("alu_rr_1A53", 16'h1A53, e);
      e = '0; e.read_a = 1; e.arg_a = 4'hB; e.imm_en = 1; e.arg_imm = 5'd9;
      e.alu_en = 1; e.alu_op = 5'h02; e.out_regs = 3'b011; e.inc_pc = 1;
      add_vec("alu_imm_2B49", 16'h2B49, e);
      e = '0; e.read_a = 1; e.arg_a = 4'h1; e.read_b = 1; e.src_b = 4'h2;
      e.alu_en = 1; e.alu_op = 5'h10; e.truth_table = 4'h6; e.out_regs = 3'b011; e.inc_pc = 1;
      add_vec("logic_3126", 16'h3126, e);
      e = '0; e.read_a = 1; e.arg_a = 4'h3; e.imm_en = 1; e.sh_off_imm = 1; e.arg_imm = 5'd7;
      e.alu_en = 1; e.alu_op = 5'h15; e.out_regs = 3'b011; e.inc_pc = 1;
      add_vec("shift_imm_4347", 16'h4347, e);
      e = '0; e.read_a = 1; e.arg_a = 4'hC; e.read_b = 1; e.src_b = 4'h7;
      e.alu_en = 1; e.alu_op = 5'h16; e.out_regs = 3'b011; e.inc_pc = 1;
      add_vec("shift_reg_5C72", 16'h5C72, e);
      e = '0; e.read_a = 1; e.arg_a = 4'hD; e.read_b = 1; e.src_b = 4'hE;
      e.alu_en = 1; e.alu_op = 5'h18; e.out_regs = 3'b010; e.inc_pc = 1;
      add_vec("cmp_6DE0", 16'h6DE0, e);
      e = '0; e.cmp_b = 3'd3; e.add_pc = 1; e.pc_src = 2'd3; e.imm_en = 1; e.arg_imm = 5'h1F;
      add_vec("branch_761F", 16'h761F, e);
      e = '0; e.set_pc = 1; e.pc_src = 2'd1;
      add_vec("jump_ext_8300", 16'h8300, e);
      e = '0; e.inc_pc = 1;
      add_vec("nop_0000", 16'h0000, e);
      add_vec("nop_9ABC", 16'h9ABC, e);

      e_jump = '0; e_jump.set_pc = 1; e_jump.pc_src = 2'd2; e_jump.read_a = 1;
      e_jump.arg_a = 4'h5; e_jump.out_regs = 3'b100;
      e_nop = '0; e_nop.inc_pc = 1;

      // Reset wins over a valid strobe.
      step(16'h1234, 16'h0000, 1'b1, 1'b1);
      check("reset_with_ins_en", actual(), '0);
      step(16'h1234, 16'h0000, 1'b1, 1'b1);
      check("reset_held", actual(), '0);

      foreach (vecs[k]) begin
         step(vecs[k].ins, vecs[k].ext, vecs[k].en, 1'b0);
         check(vecs[k].name, actual(), vecs[k].exp);
      end

      // Jump / bubble / NOP sequence, repeated with both extension values.
      for (int x = 0; x < 2; x++) begin
         logic [15:0] ev;
         ev = (x == 0) ? 16'h0000 : 16'hFFFF;
         step(16'h8506, ev, 1'b1, 1'b0);
         check("seq_jump_8506", actual(), e_jump);
         step(16'h8506, ev, 1'b0, 1'b0);
         check("seq_bubble", actual(), '0);
         step(16'hF000, ev, 1'b1, 1'b0);
         check("seq_nop_F000", actual(), e_nop);
      end

      // Reset mid-stream discards that instruction; next edge decodes again.
      step(16'h1A53, 16'h0000, 1'b1, 1'b0);
      check("pre_midreset", actual(), ref_decode(16'h1A53));
      step(16'h3126, 16'h0000, 1'b1, 1'b1);
      check("midreset_discard", actual(), '0);
      step(16'h4347, 16'h0000, 1'b1, 1'b0);
      check("first_after_reset", actual(), ref_decode(16'h4347));

      // Randomized stream against the reference model.
      for (int n = 0; n < 400; n++) begin
         logic [15:0] ri, re;
         logic        ren, rrst;
         out_t        exp_r;
         ri   = 16'($urandom);
         re   = 16'($urandom);
         ren  = ($urandom_range(0, 7) != 0);
         rrst = ($urandom_range(0, 31) == 0);
         exp_r = (rrst || !ren) ? out_t'('0) : ref_decode(ri);
         step(ri, re, ren, rrst);
         check($sformatf("rand_%0d_ins_%h", n, ri), actual(), exp_r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
